csa_wide_seq: RTL and testbench
===============================

// Module: csa_wide_seq
// PURPOSE
//  Multi-cycle sequencer for wide adds on one shared csa_16bit instance.
//  Latches two WIDTH-bit operands and feeds one 16-bit slice per cycle, LSB first.
//  Chains the carry between slices in a register, then presents the full sum and carry-out.
//  Sits between a valid/ready producer and consumer. Replaces a WIDTH-bit ripple/skip chain with NSLICE cycles.
// PARAMETERS
//  WIDTH   64            operand/sum width; multiple of 16, >=16 (else $error at elaboration)
//  NSLICE  WIDTH/16      derived localparam; slices per operation
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands/cin valid
//  in_ready   out  1      block can accept (high only in IDLE)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in to slice 0
//  out_valid  out  1      sum/cout valid (high only in DONE)
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  registered result
//  cout       out  1      carry-out of slice NSLICE-1
//  sub        in   1      only with CSA_WIDE_SUB_EN; 1 = subtract
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0.
//   Slice counter=0, carry reg=0. Takes effect immediately, mid-operation included.
//   An aborted op is lost; no partial result is ever presented.
//  FSM IDLE -> RUN -> DONE -> IDLE:
//   IDLE: in_ready=1. in_valid&&in_ready at edge T: latch a, b, cin into operand regs.
//    Set k=0, go RUN.
//   RUN: each edge adds slice k (bits 16k+15:16k) through csa_16bit.
//    Slice carry-in = carry reg (latched cin for k=0).
//    Slice sum goes into the accumulator; csa_16bit cout goes into the carry reg; k++.
//    At the edge processing k=NSLICE-1: sum<=accumulator incl. last slice, cout<=that carry.
//    Same edge goes DONE.
//   DONE: out_valid=1. sum/cout held stable until out_valid&&out_ready, then go IDLE.
//  Timing: out_valid rises after edge T+NSLICE. Min initiation interval is NSLICE+2 cycles.
//   No overlap: in_ready=0 in RUN and DONE. a, b, cin, sub changes there are ignored.
//  sum/cout change only on entry to DONE. They keep the last result in IDLE/RUN until overwritten.
//  Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
//  WIDTH=16: NSLICE=1; RUN lasts one cycle.
//  Counter width clog2(NSLICE) min 1; k wraps to 0 on entry to DONE.
//  in_valid in the DONE cycle that handshakes out: not accepted until the following IDLE cycle.
// CONFIGURATION
//  CSA_WIDE_SUB_EN defined: port sub present, latched with operands.
//   sub=1: slices use ~b and slice-0 carry-in forced to 1; cin ignored.
//   Result {cout,sum} = a + ~b + 1; cout=1 means no borrow (a>=b unsigned).
//   sub=0: identical to the add path.
//  Undefined: no sub port; add only. Timing is identical either way.
// TESTING (WIDTH=64 unless noted)
//  1. a=64'hFFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> sum=0, cout=1.
//     out_valid exactly 4 cycles after accept.
//  2. a=64'h0000_0000_FFFF_FFFF, b=0, cin=1 -> sum=64'h0000_0001_0000_0000, cout=0.
//     Checks inter-slice carry chain.
//  3. Result ready, out_ready=0 for 5 cycles with in_valid=1, new a/b.
//     Expect sum/cout stable, in_ready=0, new op not accepted until after out handshake.
//  4. Drop rst_n after 2 RUN slices -> same cycle: out_valid=0, in_ready=1, sum=0, cout=0.
//     Next op completes correctly.
//  5. CSA_WIDE_SUB_EN, a=5, b=7, sub=1 -> sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0.
//     a=7, b=5 -> sum=2, cout=1.
//  6. in_valid and out_ready held 1, 3 random ops -> accepts every 6 cycles.
//     Results match a+b+cin model. Repeat at WIDTH=16 (period 3).

Source files
------------

// File: rtl/csa_wide_seq.sv
// Multi-cycle wide adder: one shared 16-bit slice adder, LSB slice first, carry chained in a register.
// Optional subtract mode under CSA_WIDE_SUB_EN (adds port sub).

module csa_16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);
   logic [8:0] lo;
   logic [8:0] hi0;
   logic [8:0] hi1;

   // Carry-select: upper byte computed for both carry values, chosen by the lower byte's carry.
   assign lo  = {1'b0, a[7:0]}  + {1'b0, b[7:0]}  + {8'd0, cin};
   assign hi0 = {1'b0, a[15:8]} + {1'b0, b[15:8]};
   assign hi1 = {1'b0, a[15:8]} + {1'b0, b[15:8]} + 9'd1;

   assign sum  = {(lo[8] ? hi1[7:0] : hi0[7:0]), lo[7:0]};
   assign cout = lo[8] ? hi1[8] : hi0[8];
endmodule

// state  | meaning
// S_IDLE | ready for operands; in_ready=1
// S_RUN  | one 16-bit slice added per clock, LSB first
// S_DONE | result presented; out_valid=1 until consumed
module csa_wide_seq #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef CSA_WIDE_SUB_EN
   ,
   input  logic             sub
`endif
);
   localparam int NSLICE = WIDTH / 16;
   localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

   if ((WIDTH < 16) || ((WIDTH % 16) != 0)) begin : g_bad_width
      $error("csa_wide_seq: WIDTH must be a multiple of 16 and at least 16");
   end

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;

   logic [15:0]      slice_sum;
   logic             slice_cout;
   logic [WIDTH-1:0] a_nxt, b_nxt, acc_nxt;
   logic             sub_eff;

`ifdef CSA_WIDE_SUB_EN
   assign sub_eff = sub;
`else
   assign sub_eff = 1'b0;
`endif

   csa_16bit u_csa (
      .a    (a_q[15:0]),
      .b    (b_q[15:0]),
      .cin  (carry_q),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   // Operands shift down so the active slice is always bits 15:0; the accumulator fills from the top.
   if (NSLICE == 1) begin : g_one
      assign a_nxt   = a_q;
      assign b_nxt   = b_q;
      assign acc_nxt = slice_sum;
   end else begin : g_many
      assign a_nxt   = {16'd0, a_q[WIDTH-1:16]};
      assign b_nxt   = {16'd0, b_q[WIDTH-1:16]};
      assign acc_nxt = {slice_sum, acc_q[WIDTH-1:16]};
   end

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      a_d       = a_q;
      b_d       = b_q;
      carry_d   = carry_q;
      acc_d     = acc_q;
      sum_d     = sum_q;
      cout_d    = cout_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_d     = a;
               b_d     = b ^ {WIDTH{sub_eff}};
               carry_d = cin | sub_eff;
               acc_d   = '0;
               k_d     = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            a_d     = a_nxt;
            b_d     = b_nxt;
            acc_d   = acc_nxt;
            carry_d = slice_cout;
            if (k_q == K_LAST) begin
               sum_d   = acc_nxt;
               cout_d  = slice_cout;
               k_d     = '0;
               state_d = S_DONE;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         acc_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
endmodule

// File: tb/tb_csa_wide_seq.sv
// Bench for csa_wide_seq: queue-based result/timing model at WIDTH=64 plus a WIDTH=16 throughput run.
// Subtract vectors are included when CSA_WIDE_SUB_EN is defined.

module tb_csa_wide_seq;
   localparam int W  = 64;
   localparam int NS = W / 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready, out_valid, out_ready, cin, cout;
   logic [W-1:0]  a, b, sum;
   logic          in_valid16, in_ready16, out_valid16, cin16, cout16;
   logic [15:0]   a16, b16, sum16;
`ifdef CSA_WIDE_SUB_EN
   logic          sub;
   logic          sub16;
`endif

   always #5 clk = ~clk;

   csa_wide_seq #(.WIDTH(W)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout)
`ifdef CSA_WIDE_SUB_EN
      , .sub(sub)
`endif
   );

   csa_wide_seq #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
      .a(a16), .b(b16), .cin(cin16), .out_valid(out_valid16), .out_ready(1'b1),
      .sum(sum16), .cout(cout16)
`ifdef CSA_WIDE_SUB_EN
      , .sub(sub16)
`endif
   );

   int vec_cnt = 0;
   int err_cnt = 0;
   int cyc_p   = 0;

   always @(posedge clk) cyc_p <= cyc_p + 1;

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Model: each accepted op is due NS+1 negedges after the negedge that saw the handshake pending.
   typedef struct {
      logic [64:0] val;
      int          due;
   } exp_t;
   exp_t        mq[$];
   logic [64:0] last_res = '0;
   int          ncyc = 0;

   always @(negedge clk) begin
      logic [64:0] e_res;
      logic [64:0] m;
      bit          idle_m;
      bit          due_now;
      ncyc++;
      if (!rst_n) begin
         mq.delete();
         last_res = '0;
         chk("mon_rst_in_ready", 65'(in_ready), 65'd1);
         chk("mon_rst_out_valid", 65'(out_valid), 65'd0);
         chk("mon_rst_result", {cout, sum}, 65'd0);
      end else begin
         idle_m  = (mq.size() == 0);
         due_now = !idle_m && (ncyc >= mq[0].due);
         e_res   = due_now ? mq[0].val : last_res;
         chk("mon_in_ready", 65'(in_ready), 65'(idle_m));
         chk("mon_out_valid", 65'(out_valid), 65'(due_now));
         chk("mon_result", {cout, sum}, e_res);
         if (due_now && out_ready) begin
            last_res = mq[0].val;
            void'(mq.pop_front());
         end
         if (idle_m && in_valid) begin
            m = {1'b0, a} + {1'b0, b} + {64'd0, cin};
`ifdef CSA_WIDE_SUB_EN
            if (sub) m = {1'b0, a} + {1'b0, ~b} + 65'd1;
`endif
            mq.push_back('{val: m, due: ncyc + NS + 1});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_ov(output int n);
      n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
      if (!out_valid) begin
         vec_cnt++;
         err_cnt++;
         $display("FAIL timeout_out_valid: got out_valid=0 after %0d cycles, required 1", n);
      end
   endtask

   task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
      a        = av;
      b        = bv;
      cin      = cv;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      int          n;
      int          t_prev;
      logic [64:0] exp_v;
      logic [16:0] exp16;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0;
      in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
`ifdef CSA_WIDE_SUB_EN
      sub = 1'b0; sub16 = 1'b0;
`endif
      tick(); tick();
      chk("reset_in_ready", 65'(in_ready), 65'd1);
      chk("reset_result", {cout, sum}, 65'd0);
      rst_n = 1'b1;
      tick();

      // Full carry propagation through all slices, with latency check.
      start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      wait_ov(n);
      chk("t1_latency", 65'(n), 65'd4);
      chk("t1_result", {cout, sum}, {1'b1, 64'h0});
      tick();
      chk("t1_back_idle", 65'(in_ready), 65'd1);

      start_op(64'h0000_0000_FFFF_FFFF, 64'd0, 1'b1);
      wait_ov(n);
      chk("t2_result", {cout, sum}, {1'b0, 64'h0000_0001_0000_0000});
      tick();

      // Back-pressure: result held, new op refused until after the output handshake.
      out_ready = 1'b0;
      start_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
      wait_ov(n);
      a = 64'h8000_0000_0000_0000; b = 64'h8000_0000_0000_0000; cin = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t3_hold", {cout, sum}, {1'b0, 64'h2222_2222_2222_2211});
         chk("t3_in_ready_low", 65'(in_ready), 65'd0);
      end
      out_ready = 1'b1;
      tick();
      chk("t3_idle_after_hs", 65'(in_ready), 65'd1);
      tick();
      in_valid = 1'b0;
      wait_ov(n);
      chk("t3_second_result", {cout, sum}, {1'b1, 64'h1});
      tick();

      // Asynchronous reset in the middle of an operation.
      start_op(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1);
      tick(); tick();
      rst_n = 1'b0;
      #1;
      chk("t4_rst_out_valid", 65'(out_valid), 65'd0);
      chk("t4_rst_in_ready", 65'(in_ready), 65'd1);
      chk("t4_rst_result", {cout, sum}, 65'd0);
      tick();
      rst_n = 1'b1;
      tick();
      start_op(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0);
      wait_ov(n);
      chk("t4_after_rst", {cout, sum}, {1'b0, 64'h0001_0000_0001_0000});
      tick();

`ifdef CSA_WIDE_SUB_EN
      sub = 1'b1;
      start_op(64'd5, 64'd7, 1'b0);
      wait_ov(n);
      chk("t5_sub_borrow", {cout, sum}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
      tick();
      start_op(64'd7, 64'd5, 1'b1);
      wait_ov(n);
      chk("t5_sub_noborrow", {cout, sum}, {1'b1, 64'd2});
      tick();
      sub = 1'b0;
`endif

      // Back-to-back throughput at WIDTH=64: one result every NS+2 cycles.
      out_ready = 1'b1;
      t_prev = 0;
      a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()}; cin = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exp_v = {1'b0, a} + {1'b0, b} + {64'd0, cin};
         wait_ov(n);
         chk("t6_result", {cout, sum}, exp_v);
         if (i > 0) chk("t6_period", 65'(cyc_p - t_prev), 65'd6);
         t_prev = cyc_p;
         a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()}; cin = 1'($urandom_range(0, 1));
         tick();
      end
      in_valid = 1'b0;
      tick(); tick();

      // Same at WIDTH=16: single-slice run, period 3.
      a16 = 16'($urandom()); b16 = 16'($urandom()); cin16 = 1'b1;
      in_valid16 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exp16 = {1'b0, a16} + {1'b0, b16} + {16'd0, cin16};
         n = 0;
         while (!out_valid16 && n < 20) begin
            tick();
            n++;
         end
         chk("t6w16_valid", 65'(out_valid16), 65'd1);
         chk("t6w16_result", 65'({cout16, sum16}), 65'(exp16));
         if (i > 0) chk("t6w16_period", 65'(cyc_p - t_prev), 65'd3);
         t_prev = cyc_p;
         a16 = 16'($urandom()); b16 = 16'($urandom()); cin16 = 1'($urandom_range(0, 1));
         tick();
      end
      in_valid16 = 1'b0;
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
